// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - serialises instruction-fetch and data accesses onto one single-ported memory
module mem_port_arbiter #(
  parameter int AW         = 6,
  parameter int LATENCY    = 1,
  parameter int MAX_STREAK = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  output logic          if_valid,
  output logic [31:0]   if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [31:0]   d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_valid,
  output logic [31:0]   d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          stall
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0] state;
  logic [3:0] streak;
  logic [3:0] wait_cnt;
  logic       win_fetch;
  logic       lat_we;
  logic       fetch_wins;

  // Data has priority unless fetch has been starved for MAX_STREAK grants.
  assign fetch_wins = if_req & (~d_req | (streak == 4'(MAX_STREAK)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      streak    <= 4'd0;
      wait_cnt  <= 4'd0;
      win_fetch <= 1'b0;
      lat_we    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      if_rdata  <= 32'd0;
      d_rdata   <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (if_req | d_req) begin
            state     <= S_ISSUE;
            mem_en    <= 1'b1;
            win_fetch <= fetch_wins;
            if (fetch_wins) begin
              lat_we    <= 1'b0;
              mem_we    <= 1'b0;
              mem_addr  <= if_addr[AW+1:2];
              mem_wdata <= 32'd0;
              streak    <= 4'd0;
            end else begin
              lat_we    <= d_we;
              mem_we    <= d_we;
              mem_addr  <= d_addr[AW+1:2];
              mem_wdata <= d_wdata;
              if (if_req)
                streak <= (streak < 4'(MAX_STREAK)) ? streak + 4'd1 : streak;
              else
                streak <= 4'd0;
            end
          end
        end
        S_ISSUE: begin
          state    <= S_WAIT;
          mem_en   <= 1'b0;
          mem_we   <= 1'b0;
          wait_cnt <= 4'(LATENCY - 1);
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= S_DONE;
            // Read data lands on the last wait cycle; stores leave both rdata registers alone.
            if (!lat_we) begin
              if (win_fetch) if_rdata <= mem_rdata;
              else           d_rdata  <= mem_rdata;
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign if_valid = (state == S_DONE) &  win_fetch;
  assign d_valid  = (state == S_DONE) & ~win_fetch;
  assign stall    = (if_req & ~if_valid) | (d_req & ~d_valid);

  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:AW+2], if_addr[1:0], d_addr[31:AW+2], d_addr[1:0]};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int AW   = 6;
  localparam int LAT  = 3;
  localparam int MAXS = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0;
  logic [31:0]   if_addr = 32'd0;
  logic          if_valid;
  logic [31:0]   if_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [31:0]   d_addr = 32'd0;
  logic [31:0]   d_wdata = 32'd0;
  logic          d_valid;
  logic [31:0]   d_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = 32'd0;
  logic          stall;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_on  = 1'b0;
  bit if_keep = 1'b0;
  bit d_keep  = 1'b0;
  bit rd_auto = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .LATENCY(LAT), .MAX_STREAK(MAXS)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall(stall)
  );

  // Transaction model: a grant at cycle t0 issues at t0+1, captures at t0+1+LAT, completes at t0+2+LAT.
  bit            m_busy = 1'b0;
  bit            m_fetch = 1'b0;
  bit            m_we = 1'b0;
  int            m_t0 = 0;
  int            m_streak = 0;
  logic [AW-1:0] m_addr = '0;
  logic [31:0]   m_wdata = 32'd0;
  logic [31:0]   m_if_rdata = 32'd0;
  logic [31:0]   m_d_rdata = 32'd0;
  logic          m_fetch_wins;
  int            e_rel;
  logic          e_en, e_ifv, e_dv, e_stall;

  assign m_fetch_wins = if_req && (!d_req || m_streak == MAXS);
  assign e_rel   = cyc - m_t0;
  assign e_en    = m_busy && (e_rel == 1);
  assign e_ifv   = m_busy && m_fetch && (e_rel == 2 + LAT);
  assign e_dv    = m_busy && !m_fetch && (e_rel == 2 + LAT);
  assign e_stall = (if_req && !e_ifv) || (d_req && !e_dv);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_busy     <= 1'b0;
      m_streak   <= 0;
      m_if_rdata <= 32'd0;
      m_d_rdata  <= 32'd0;
    end else if (!m_busy) begin
      if (if_req || d_req) begin
        m_busy  <= 1'b1;
        m_t0    <= cyc;
        m_fetch <= m_fetch_wins;
        if (m_fetch_wins) begin
          m_we     <= 1'b0;
          m_addr   <= AW'(if_addr / 4);
          m_streak <= 0;
        end else begin
          m_we     <= d_we;
          m_addr   <= AW'(d_addr / 4);
          m_wdata  <= d_wdata;
          m_streak <= if_req ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
        end
      end
    end else begin
      if (cyc == m_t0 + 1 + LAT && !m_we) begin
        if (m_fetch) m_if_rdata <= mem_rdata;
        else         m_d_rdata  <= mem_rdata;
      end
      if (cyc == m_t0 + 2 + LAT) m_busy <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("if_valid", 32'(if_valid), 32'(e_ifv));
      chk("d_valid",  32'(d_valid),  32'(e_dv));
      chk("mem_en",   32'(mem_en),   32'(e_en));
      chk("mem_we",   32'(mem_we),   32'(e_en && m_we));
      chk("stall",    32'(stall),    32'(e_stall));
      chk("if_rdata", if_rdata, m_if_rdata);
      chk("d_rdata",  d_rdata,  m_d_rdata);
      if (e_en) begin
        chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (if_valid && !if_keep) if_req = 1'b0;
    if (d_valid && !d_keep)   d_req  = 1'b0;
    if (rd_auto) mem_rdata = {16'hA5A5, cyc[15:0]};
  endtask

  initial begin
    string seq;
    seq = "";
    rst = 1'b1;
    step();
    step();
    chk_on = 1'b1;
    chk("rst_mem_en",   32'(mem_en), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_valids",   32'({if_valid, d_valid}), 32'd0);
    chk("rst_rdata",    if_rdata | d_rdata, 32'd0);
    chk("rst_stall",    32'(stall), 32'd0);
    rst = 1'b0;
    step();

    // Fetch only
    mem_rdata = 32'hDEADBEEF;
    if_addr = 32'h10;
    if_req = 1'b1;
    step();
    chk("t1_mem_en", 32'(mem_en), 32'd1);
    chk("t1_mem_addr", 32'(mem_addr), 32'd4);
    if_addr = 32'h0;
    step();
    chk("t1_stall", 32'(stall), 32'd1);
    repeat (LAT) step();
    chk("t1_if_valid", 32'(if_valid), 32'd1);
    chk("t1_if_rdata", if_rdata, 32'hDEADBEEF);
    step();

    // Fetch and load together: data first
    mem_rdata = 32'h00001234;
    if_addr = 32'h44;
    d_addr = 32'h20;
    d_we = 1'b0;
    if_req = 1'b1;
    d_req = 1'b1;
    step();
    chk("t2_d_addr", 32'(mem_addr), 32'd8);
    repeat (LAT + 1) step();
    chk("t2_d_valid", 32'(d_valid), 32'd1);
    chk("t2_d_rdata", d_rdata, 32'h00001234);
    chk("t2_stall_mid", 32'(stall), 32'd1);
    repeat (2) step();
    chk("t2_f_issue", 32'(mem_en), 32'd1);
    chk("t2_f_addr", 32'(mem_addr), 32'h11);
    repeat (LAT) step();
    chk("t2_stall_end", 32'(stall), 32'd1);
    step();
    chk("t2_if_valid", 32'(if_valid), 32'd1);
    step();

    // Store
    mem_rdata = 32'hFFFF0000;
    d_we = 1'b1;
    d_addr = 32'h08;
    d_wdata = 32'h12345678;
    d_req = 1'b1;
    step();
    chk("t3_en_we", 32'({mem_en, mem_we}), 32'd3);
    chk("t3_addr", 32'(mem_addr), 32'd2);
    chk("t3_wdata", mem_wdata, 32'h12345678);
    step();
    chk("t3_we_once", 32'(mem_we), 32'd0);
    repeat (LAT) step();
    chk("t3_d_valid", 32'(d_valid), 32'd1);
    chk("t3_d_rdata_kept", d_rdata, 32'h00001234);
    d_we = 1'b0;
    step();

    // Starvation limit with both held continuously
    rd_auto = 1'b1;
    if_addr = 32'h3C;
    d_addr = 32'hFFFFFF82;
    if_keep = 1'b1;
    d_keep = 1'b1;
    if_req = 1'b1;
    d_req = 1'b1;
    for (int i = 0; i < 80 && seq.len() < 10; i++) begin
      step();
      if (mem_en) seq = {seq, (mem_addr == 6'd15) ? "F" : (mem_addr == 6'd32) ? "D" : "?"};
    end
    n_tests++;
    if (seq != "DDDDFDDDDF") begin
      n_fail++;
      $display("FAIL t4_grant_order: got %s, expected DDDDFDDDDF", seq);
    end
    d_req = 1'b0;
    d_keep = 1'b0;
    if_keep = 1'b0;
    repeat (LAT + 3) step();

    // Reset mid-wait, fetch held through reset
    rd_auto = 1'b0;
    mem_rdata = 32'h5555AAAA;
    if_addr = 32'h24;
    if_req = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_outs_zero", 32'({if_valid, d_valid, mem_en, mem_we}), 32'd0);
    chk("t5_rdata_zero", if_rdata | d_rdata, 32'd0);
    step();
    chk("t5_reissue", 32'(mem_en), 32'd1);
    chk("t5_addr", 32'(mem_addr), 32'd9);
    repeat (LAT) step();
    chk("t5_no_early_valid", 32'(if_valid), 32'd0);
    step();
    chk("t5_if_valid", 32'(if_valid), 32'd1);
    chk("t5_if_rdata", if_rdata, 32'h5555AAAA);
    step();

    // Capture exactly on the last wait cycle
    mem_rdata = 32'h00000BAD;
    d_addr = 32'h30;
    d_req = 1'b1;
    for (int k = 1; k <= 2 + LAT; k++) begin
      step();
      mem_rdata = (k == 1 + LAT) ? 32'h00C0FFEE : 32'h00000BAD;
    end
    chk("t6_d_valid", 32'(d_valid), 32'd1);
    chk("t6_d_rdata", d_rdata, 32'h00C0FFEE);
    step();

    // Random traffic with fields changing freely, one reset pulse
    rd_auto = 1'b1;
    for (int i = 0; i < 400; i++) begin
      step();
      rst = (i == 200);
      if (!if_req && ($urandom % 3 == 0)) if_req = 1'b1;
      if (!d_req && ($urandom % 3 == 0)) d_req = 1'b1;
      if ($urandom % 2 == 0) if_addr = $urandom;
      if ($urandom % 2 == 0) begin
        d_addr = $urandom;
        d_we = 1'($urandom % 2);
        d_wdata = $urandom;
      end
    end
    rst = 1'b0;
    repeat (40) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
